mem_stage_unit: RTL and testbench
=================================

// Module: mem_stage_unit
// PURPOSE
//   MEM-stage consumer of the EX/MEM pipeline register outputs. Drives a variable-latency
//   data-memory req/ack handshake for loads/stores, stalls the upstream pipeline while an
//   access is outstanding, and holds the MEM/WB pipeline register feeding write-back.
//   Flags misaligned/illegal/timed-out accesses as a per-instruction error to WB.
// PARAMETERS
//   DATA_W      32  data/address width
//   REG_W       5   destination register index width
//   TIMEOUT_CYC 16  max cycles an access may wait for dmem_ack before abort (>=2)
// PORTS
//   clk           in   1       rising-edge clock
//   reset         in   1       synchronous, active-high reset
//   wb_source_m   in   1       1 = write back load data, 0 = ALU result
//   mem_rd_en_m   in   1       load request
//   mem_wr_en_m   in   1       store request
//   reg_write_m   in   1       instruction writes register file
//   alu_out_m     in   DATA_W  ALU result / memory byte address
//   write_data_m  in   DATA_W  store data
//   register_d_m  in   REG_W   destination register
//   dmem_req      out  1       memory request valid
//   dmem_we       out  1       1 = write, 0 = read
//   dmem_addr     out  DATA_W  = alu_out_m
//   dmem_wdata    out  DATA_W  = write_data_m
//   dmem_ack      in   1       access complete; rdata valid same cycle
//   dmem_rdata    in   DATA_W  load data
//   stall_mem     out  1       freeze PC, IF/ID, ID/EX, EX/MEM (EX/MEM inputs held stable)
//   wb_source_w   out  1       MEM/WB: registered wb_source_m
//   reg_write_w   out  1       MEM/WB: register write enable (0 on bubble/error)
//   read_data_w   out  DATA_W  MEM/WB: captured dmem_rdata
//   alu_out_w     out  DATA_W  MEM/WB: registered alu_out_m
//   register_d_w  out  REG_W   MEM/WB: registered register_d_m
//   err_w         out  1       MEM/WB: access error for this instruction
// BEHAVIOUR
//   Reset: state=IDLE, wait_cnt=0, all *_w outputs 0. dmem_req/stall_mem combinational,
//     low whenever no access is presented in IDLE.
//   access = rd_en ^ wr_en; illegal = rd_en & wr_en; misaligned = access & alu_out_m[1:0]!=0.
//   Illegal or misaligned: no dmem_req, no stall; next cycle err_w=1, reg_write_w=0.
//   dmem_we=mem_wr_en_m; dmem_addr/wdata driven straight from inputs.
//   FSM IDLE: valid access -> dmem_req=1. ack same cycle -> complete, stall_mem=0, stay IDLE.
//     No ack -> stall_mem=1, go WAIT, wait_cnt<=0.
//   FSM WAIT: dmem_req=1. ack -> complete, stall_mem=0, go IDLE (ack beats timeout).
//     No ack, wait_cnt<TIMEOUT_CYC-1 -> stall_mem=1, wait_cnt++.
//     No ack, wait_cnt==TIMEOUT_CYC-1 -> abort: stall_mem=0, err_w=1 next cycle, go IDLE.
//   MEM/WB update every cycle (not gated by stall): stall cycle -> bubble (reg_write_w=0,
//     err_w=0, other fields don't-care but registered); else capture inputs, read_data_w
//     <= dmem_rdata on completed load, else 0. Latency: completion/non-mem op -> *_w +1 cycle.
//   Store/non-mem/error: read_data_w=0. Completed store: reg_write_w=reg_write_m (normally 0).
//   dmem_ack ignored whenever dmem_req=0 (stale acks after reset/abort discarded).
//   Reset mid-WAIT: next cycle IDLE, *_w cleared; if EX/MEM still presents the access it
//     is reissued from IDLE.
// TESTING
//   ALU op alu_out_m=0x1234, reg_write_m=1, rd=5 -> next cycle alu_out_w=0x1234, reg_write_w=1, register_d_w=5; dmem_req never 1.
//   Load addr 0x100, ack+rdata 0xDEADBEEF same cycle -> stall_mem never 1; next cycle read_data_w=0xDEADBEEF, wb_source_w=1.
//   Store addr 0x200 data 0xCAFEF00D, ack on 3rd req cycle -> dmem_we=1 3 cycles, stall_mem=1,1,0; bubbles on *_w for 2 cycles.
//   Load addr 0x102 (misaligned) and rd_en=wr_en=1 -> dmem_req=0, stall_mem=0; next cycle err_w=1, reg_write_w=0.
//   TIMEOUT_CYC=4, load, ack never -> stall_mem high 4 cycles, low on 5th; err_w=1 on 6th; state IDLE.
//   Reset asserted in WAIT (wait_cnt=2) -> next cycle *_w=0, wait_cnt=0, dmem_req reissued from IDLE; late ack completes normally.

Source files
------------

// File: rtl/mem_stage_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_unit
// Brief    : MEM stage - data-memory req/ack handshake, stall, MEM/WB register
// Revision : 1.0
// ============================================================================
module mem_stage_unit #(
    parameter int DATA_W      = 32,
    parameter int REG_W       = 5,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_source_m,
    input  logic              mem_rd_en_m,
    input  logic              mem_wr_en_m,
    input  logic              reg_write_m,
    input  logic [DATA_W-1:0] alu_out_m,
    input  logic [DATA_W-1:0] write_data_m,
    input  logic [REG_W-1:0]  register_d_m,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall_mem,
    output logic              wb_source_w,
    output logic              reg_write_w,
    output logic [DATA_W-1:0] read_data_w,
    output logic [DATA_W-1:0] alu_out_w,
    output logic [REG_W-1:0]  register_d_w,
    output logic              err_w
);

    localparam int c_cnt_w = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT_CYC - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_wait_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;

    logic w_access, w_illegal, w_misaligned, w_bad;
    logic w_req, w_stall, w_abort, w_done, w_err;

    logic              r_wb_source;
    logic              r_reg_write;
    logic [DATA_W-1:0] r_read_data;
    logic [DATA_W-1:0] r_alu_out;
    logic [REG_W-1:0]  r_register_d;
    logic              r_err;

    assign w_access     = mem_rd_en_m ^ mem_wr_en_m;
    assign w_illegal    = mem_rd_en_m & mem_wr_en_m;
    assign w_misaligned = w_access & (alu_out_m[1:0] != 2'b00);
    // While waiting, EX/MEM is frozen on an access already found legal
    assign w_bad        = (r_state == S_IDLE) & (w_illegal | w_misaligned);

    always_comb begin
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_abort     = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_wait_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_access && !w_misaligned) begin
                    w_req = 1'b1;
                    if (!dmem_ack) begin
                        w_stall     = 1'b1;
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            S_WAIT: begin
                w_req = 1'b1;
                if (dmem_ack) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_wait_cnt < c_cnt_max) begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_wait_cnt + c_cnt_w'(1);
                end else begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // An ack without an outstanding request is stale and must not complete anything
    assign w_done = w_req & dmem_ack;
    assign w_err  = w_bad | w_abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= '0;
            r_wb_source  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_read_data  <= '0;
            r_alu_out    <= '0;
            r_register_d <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wait_cnt   <= w_cnt_nxt;
            r_wb_source  <= wb_source_m;
            r_alu_out    <= alu_out_m;
            r_register_d <= register_d_m;
            r_reg_write  <= reg_write_m & ~w_err & ~w_stall;
            r_err        <= w_err & ~w_stall;
            r_read_data  <= (w_done && !mem_wr_en_m) ? dmem_rdata : '0;
        end
    end

    assign dmem_req     = w_req;
    assign dmem_we      = mem_wr_en_m;
    assign dmem_addr    = alu_out_m;
    assign dmem_wdata   = write_data_m;
    assign stall_mem    = w_stall;
    assign wb_source_w  = r_wb_source;
    assign reg_write_w  = r_reg_write;
    assign read_data_w  = r_read_data;
    assign alu_out_w    = r_alu_out;
    assign register_d_w = r_register_d;
    assign err_w        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_unit
// Brief    : Directed plus random bench for mem_stage_unit with reference model
// Revision : 1.0
// ============================================================================
module tb_mem_stage_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_source_m, mem_rd_en_m, mem_wr_en_m, reg_write_m;
    logic [31:0] alu_out_m, write_data_m;
    logic [4:0]  register_d_m;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall_mem, wb_source_w, reg_write_w, err_w;
    logic [31:0] read_data_w, alu_out_w;
    logic [4:0]  register_d_w;

    int total = 0;
    int bad   = 0;

    // Reference model: an access is pending for m_n request cycles so far
    bit m_busy  = 1'b0;
    int m_n     = 0;
    bit m_known = 1'b0;
    logic last_stall, last_req;

    always #5 clk = ~clk;

    mem_stage_unit #(.DATA_W(32), .REG_W(5), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset(reset),
        .wb_source_m(wb_source_m), .mem_rd_en_m(mem_rd_en_m), .mem_wr_en_m(mem_wr_en_m),
        .reg_write_m(reg_write_m), .alu_out_m(alu_out_m), .write_data_m(write_data_m),
        .register_d_m(register_d_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_mem(stall_mem),
        .wb_source_w(wb_source_w), .reg_write_w(reg_write_w), .read_data_w(read_data_w),
        .alu_out_w(alu_out_w), .register_d_w(register_d_w), .err_w(err_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic rw, input logic wbs,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rdst);
        mem_rd_en_m = rd;  mem_wr_en_m = wr;  reg_write_m = rw;  wb_source_m = wbs;
        alu_out_m = addr;  write_data_m = wd; register_d_m = rdst;
    endtask

    // One clock: check combinational outputs mid-cycle, then MEM/WB after the edge
    task automatic cycle(input logic a, input logic [31:0] rdv, input logic rst_v);
        logic acc, bad_in, req_e, done_e, abort_e, stall_e, err_e;
        logic [31:0] rdata_e, alu_e;
        logic [4:0]  rdst_e;
        logic        wbs_e, rw_e;
        int ncur;
        dmem_ack = a; dmem_rdata = rdv; reset = rst_v;
        @(negedge clk);
        acc     = mem_rd_en_m ^ mem_wr_en_m;
        bad_in  = !m_busy && ((mem_rd_en_m && mem_wr_en_m) || (acc && alu_out_m[1:0] != 2'b00));
        req_e   = m_busy || (acc && !bad_in);
        ncur    = m_busy ? m_n + 1 : 1;
        done_e  = req_e && a;
        abort_e = req_e && !a && (ncur == T + 1);
        stall_e = req_e && !a && !abort_e;
        err_e   = bad_in || abort_e;
        last_stall = stall_mem;
        last_req   = dmem_req;
        if (!rst_v && m_known) begin
            chk("dmem_req", {31'd0, dmem_req}, {31'd0, req_e});
            chk("stall_mem", {31'd0, stall_mem}, {31'd0, stall_e});
            if (req_e) begin
                chk("dmem_we", {31'd0, dmem_we}, {31'd0, mem_wr_en_m});
                chk("dmem_addr", dmem_addr, alu_out_m);
                chk("dmem_wdata", dmem_wdata, write_data_m);
            end
        end
        rdata_e = (done_e && !mem_wr_en_m) ? rdv : 32'd0;
        alu_e   = alu_out_m;
        rdst_e  = register_d_m;
        wbs_e   = wb_source_m;
        rw_e    = !stall_e && reg_write_m && !err_e;
        @(posedge clk);
        #1;
        if (rst_v) begin
            chk("rst_reg_write_w", {31'd0, reg_write_w}, 32'd0);
            chk("rst_err_w", {31'd0, err_w}, 32'd0);
            chk("rst_read_data_w", read_data_w, 32'd0);
            chk("rst_alu_out_w", alu_out_w, 32'd0);
            chk("rst_register_d_w", {27'd0, register_d_w}, 32'd0);
            chk("rst_wb_source_w", {31'd0, wb_source_w}, 32'd0);
            m_busy = 1'b0; m_n = 0; m_known = 1'b1;
        end else begin
            chk("reg_write_w", {31'd0, reg_write_w}, {31'd0, rw_e});
            chk("err_w", {31'd0, err_w}, {31'd0, (!stall_e && err_e)});
            if (!stall_e) begin
                chk("read_data_w", read_data_w, rdata_e);
                chk("alu_out_w", alu_out_w, alu_e);
                chk("register_d_w", {27'd0, register_d_w}, {27'd0, rdst_e});
                chk("wb_source_w", {31'd0, wb_source_w}, {31'd0, wbs_e});
            end
            m_busy = stall_e;
            m_n    = stall_e ? ncur : 0;
        end
    endtask

    initial begin
        logic [2:0]  sseq3;
        logic [4:0]  sseq5;
        logic [31:0] tmp;
        int          op;
        logic        a, r;

        set_op(0, 0, 0, 0, 32'd0, 32'd0, 5'd0);
        dmem_ack = 0; dmem_rdata = 0; reset = 1;
        cycle(0, 32'd0, 1);
        cycle(0, 32'd0, 1);

        // ALU op, stale ack present
        set_op(0, 0, 1, 0, 32'h1234, 32'h0, 5'd5);
        cycle(1, 32'h1111_2222, 0);
        chk("alu_req_low", {31'd0, last_req}, 32'd0);
        chk("alu_value", alu_out_w, 32'h1234);
        chk("alu_rd", {27'd0, register_d_w}, 32'd5);

        // Zero-wait load
        set_op(1, 0, 1, 1, 32'h100, 32'h0, 5'd3);
        cycle(1, 32'hDEAD_BEEF, 0);
        chk("load_no_stall", {31'd0, last_stall}, 32'd0);
        chk("load_data", read_data_w, 32'hDEAD_BEEF);

        // Store acked on third request cycle
        set_op(0, 1, 0, 0, 32'h200, 32'hCAFE_F00D, 5'd0);
        sseq3 = '0;
        for (int k = 0; k < 3; k++) begin
            cycle(k == 2, 32'h0, 0);
            sseq3 = {sseq3[1:0], last_stall};
        end
        chk("store_stall_seq", {29'd0, sseq3}, 32'b110);

        // Misaligned load, then illegal rd+wr
        set_op(1, 0, 1, 1, 32'h102, 32'h0, 5'd9);
        cycle(1, 32'h5, 0);
        chk("misalign_err", {31'd0, err_w}, 32'd1);
        set_op(1, 1, 1, 0, 32'h100, 32'h0, 5'd9);
        cycle(0, 32'h0, 0);
        chk("illegal_err", {31'd0, err_w}, 32'd1);
        chk("illegal_rw", {31'd0, reg_write_w}, 32'd0);

        // Timeout with no ack
        set_op(1, 0, 1, 1, 32'h300, 32'h0, 5'd4);
        sseq5 = '0;
        for (int k = 0; k < T + 1; k++) begin
            cycle(0, 32'h0, 0);
            sseq5 = {sseq5[3:0], last_stall};
        end
        chk("timeout_stall_seq", {27'd0, sseq5}, 32'b11110);
        chk("timeout_err", {31'd0, err_w}, 32'd1);
        set_op(0, 0, 0, 0, 32'h8, 32'h0, 5'd0);
        cycle(0, 32'h0, 0);
        chk("timeout_idle", {31'd0, last_req}, 32'd0);

        // Reset mid-wait, then reissued access completes
        set_op(1, 0, 1, 1, 32'h400, 32'h0, 5'd7);
        for (int k = 0; k < 3; k++) cycle(0, 32'h0, 0);
        cycle(1, 32'h0, 1);
        cycle(1, 32'h55AA, 0);
        chk("reissue_req", {31'd0, last_req}, 32'd1);
        chk("reissue_data", read_data_w, 32'h55AA);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            if (!m_busy) begin
                op  = $urandom_range(0, 7);
                tmp = $urandom;
                tmp = (tmp & ~32'h3) | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
                set_op(op == 2 || op == 3 || op == 4 || op == 7, op == 5 || op == 6 || op == 7,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       tmp, $urandom, 5'($urandom_range(0, 31)));
            end
            a = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 99) == 0);
            cycle(a, $urandom, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
